vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_axis_timing.sv | 77 +++++++
 rtl/vga_timing.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: the per-axis phase encoding and the
// 640x480@60 default timing used as parameter defaults.
package vga_pkg;

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_e;

    localparam int VGA_H_VISIBLE     = 640;
    localparam int VGA_H_FRONT_PORCH = 16;
    localparam int VGA_H_SYNC_PULSE  = 96;
    localparam int VGA_H_BACK_PORCH  = 48;

    localparam int VGA_V_VISIBLE     = 480;
    localparam int VGA_V_FRONT_PORCH = 10;
    localparam int VGA_V_SYNC_PULSE  = 2;
    localparam int VGA_V_BACK_PORCH  = 33;

    localparam int VGA_COL_W = 10;
    localparam int VGA_ROW_W = 10;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// One raster axis (horizontal or vertical): position counter, phase FSM and
// sync level, all advanced by step_i; wrap_o flags the step that returns to 0.
module vga_axis_timing
    import vga_pkg::*;
#(
    parameter int VISIBLE  = VGA_H_VISIBLE,
    parameter int FRONT    = VGA_H_FRONT_PORCH,
    parameter int SYNC     = VGA_H_SYNC_PULSE,
    parameter int BACK     = VGA_H_BACK_PORCH,
    parameter bit SYNC_POL = 1'b0,
    parameter int W        = VGA_COL_W
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         step_i,
    output logic [W-1:0] count_o,
    output logic         sync_o,
    output logic         active_d_o,
    output logic         wrap_o
);

    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    localparam logic [W-1:0] LAST_VISIBLE = W'(VISIBLE - 1);
    localparam logic [W-1:0] LAST_FRONT   = W'(VISIBLE + FRONT - 1);
    localparam logic [W-1:0] LAST_SYNC    = W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [W-1:0] LAST_TOTAL   = W'(TOTAL - 1);

    // Empty porches are fine (their phase is skipped); an empty visible or
    // sync segment would make the raster meaningless.
    if (VISIBLE < 1 || SYNC < 1) begin : g_bad_segment
        $fatal(1, "vga_axis_timing: VISIBLE and SYNC segments must be non-zero");
    end

    phase_e       phase_q, phase_d;
    logic [W-1:0] count_q, count_d;
    logic         sync_q;

    assign wrap_o = step_i && (count_q == LAST_TOTAL);

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (step_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
            unique case (phase_q)
                PH_VISIBLE: if (count_q == LAST_VISIBLE)
                                phase_d = (FRONT > 0) ? PH_FRONT : PH_SYNC;
                PH_FRONT:   if (count_q == LAST_FRONT)
                                phase_d = PH_SYNC;
                PH_SYNC:    if (count_q == LAST_SYNC)
                                phase_d = (BACK > 0) ? PH_BACK : PH_VISIBLE;
                PH_BACK:    if (count_q == LAST_TOTAL)
                                phase_d = PH_VISIBLE;
                default:    phase_d = PH_VISIBLE;
            endcase
        end
    end

    // Sync is registered from the next phase so it lines up with count_q.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
            phase_q <= PH_VISIBLE;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            sync_q  <= (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign count_o    = count_q;
    assign sync_o     = sync_q;
    assign active_d_o = (phase_d == PH_VISIBLE);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: column/row position, syncs, visible flag and
// line/frame start pulses. Define VGA_TIMING_ADDR_EN to add addr_o.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE     = VGA_H_VISIBLE,
    parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
    parameter int H_SYNC_PULSE  = VGA_H_SYNC_PULSE,
    parameter int H_BACK_PORCH  = VGA_H_BACK_PORCH,
    parameter int V_VISIBLE     = VGA_V_VISIBLE,
    parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
    parameter int V_SYNC_PULSE  = VGA_V_SYNC_PULSE,
    parameter int V_BACK_PORCH  = VGA_V_BACK_PORCH,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int COL_W         = VGA_COL_W,
    parameter int ROW_W         = VGA_ROW_W
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    output logic [COL_W-1:0] column_o,
    output logic [ROW_W-1:0] row_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             visible_o,
    output logic             line_start_o,
`ifdef VGA_TIMING_ADDR_EN
    output logic [$clog2(H_VISIBLE*V_VISIBLE)-1:0] addr_o,
`endif
    output logic             frame_start_o
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);

    if (H_TOTAL - 1 >= (longint'(1) << COL_W)) begin : g_col_w_check
        $fatal(1, "vga_timing: H_TOTAL-1 does not fit in COL_W bits");
    end
    if (V_TOTAL - 1 >= (longint'(1) << ROW_W)) begin : g_row_w_check
        $fatal(1, "vga_timing: V_TOTAL-1 does not fit in ROW_W bits");
    end

    logic h_wrap, v_wrap;
    logic h_active_d, v_active_d;
    logic line_start_q, frame_start_q, visible_q;

    // The vertical axis steps once per line, on the horizontal wrap.
    vga_axis_timing #(
        .VISIBLE  (H_VISIBLE),
        .FRONT    (H_FRONT_PORCH),
        .SYNC     (H_SYNC_PULSE),
        .BACK     (H_BACK_PORCH),
        .SYNC_POL (H_SYNC_POL),
        .W        (COL_W)
    ) u_h_axis (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .step_i     (enable_i),
        .count_o    (column_o),
        .sync_o     (hsync_o),
        .active_d_o (h_active_d),
        .wrap_o     (h_wrap)
    );

    vga_axis_timing #(
        .VISIBLE  (V_VISIBLE),
        .FRONT    (V_FRONT_PORCH),
        .SYNC     (V_SYNC_PULSE),
        .BACK     (V_BACK_PORCH),
        .SYNC_POL (V_SYNC_POL),
        .W        (ROW_W)
    ) u_v_axis (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .step_i     (h_wrap),
        .count_o    (row_o),
        .sync_o     (vsync_o),
        .active_d_o (v_active_d),
        .wrap_o     (v_wrap)
    );

    // Flags are registered from the axes' next phases, so they describe the
    // same position the counters show in the same cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            visible_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            visible_q     <= h_active_d & v_active_d;
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap & v_wrap;
        end
    end

    assign visible_o     = visible_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

`ifdef VGA_TIMING_ADDR_EN
    localparam int ADDR_W = $clog2(H_VISIBLE * V_VISIBLE);

    logic [ADDR_W-1:0] addr_q, addr_d;

    // The address counts pixels already shown this frame, so it advances
    // after each visible pixel and freezes through blanking.
    always_comb begin
        addr_d = addr_q;
        if (h_wrap && v_wrap) begin
            addr_d = '0;
        end else if (enable_i && visible_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
`endif

endmodule
